// File: rtl/fpu_dispatch.sv
// fpu_dispatch: command front-end for the FPU controller.
// Buffers host commands in a FIFO, issues them one at a time to the controller
// (honouring fpu_busy), waits for the result with a timeout and returns it on a
// valid/ready response channel. One operation in flight; responses in order.
// Ports:
//   clk, srstn                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            host command handshake
//   cmd_op/cmd_a/cmd_b/cmd_tag     command payload
//   rsp_valid/rsp_ready            host response handshake
//   rsp_result/rsp_tag/rsp_err     response payload
//   fpu_a/fpu_b/fpu_op/fpu_enable  to controller
//   fpu_busy/fpu_valid/fpu_result  from controller
module fpu_dispatch #(
  parameter int unsigned PRECISION_LEN = 64,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TAG_W         = 4,
  parameter int unsigned TIMEOUT       = 63
) (
  input  logic                     clk,
  input  logic                     srstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [PRECISION_LEN-1:0] cmd_a,
  input  logic [PRECISION_LEN-1:0] cmd_b,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PRECISION_LEN-1:0] rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_err,
  output logic [PRECISION_LEN-1:0] fpu_a,
  output logic [PRECISION_LEN-1:0] fpu_b,
  output logic [3:0]               fpu_op,
  output logic                     fpu_enable,
  input  logic                     fpu_busy,
  input  logic                     fpu_valid,
  input  logic [PRECISION_LEN-1:0] fpu_result
);

  localparam int unsigned OP_W = 4;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic [OP_W-1:0]          op;
    logic [PRECISION_LEN-1:0] a;
    logic [PRECISION_LEN-1:0] b;
    logic [TAG_W-1:0]         tag;
  } cmd_t;

  cmd_t                     mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e                   state_q, state_d;
  logic [1:0]               lag_q, lag_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [PRECISION_LEN-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]         rsp_tag_q, rsp_tag_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [PRECISION_LEN-1:0] fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [OP_W-1:0]          fpu_op_q, fpu_op_d;
  logic                     fpu_enable_q, fpu_enable_d;
  logic [TAG_W-1:0]         cur_tag_q, cur_tag_d;

  logic push, pop, empty, legal;
  cmd_t head;

  assign push  = cmd_valid && cmd_ready_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign legal = (head.op >= OP_W'(1)) && (head.op <= OP_W'(9));

  // FIFO storage; contents need no reset since the pointers qualify them
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    lag_d        = (lag_q != 2'd0) ? lag_q - 2'd1 : lag_q;
    timer_d      = timer_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    fpu_op_d     = '0;
    fpu_enable_d = 1'b0;
    cur_tag_d    = cur_tag_q;

    case (state_q)
      S_IDLE: begin
        if (!empty && !fpu_busy) begin
          pop       = 1'b1;
          cur_tag_d = head.tag;
          if (legal) begin
            state_d      = S_ISSUE;
            fpu_enable_d = 1'b1;
            fpu_op_d     = head.op;
            fpu_a_d      = head.a;
            fpu_b_d      = head.b;
            // lag counts down through ISSUE so it reaches 0 two cycles after issue
            lag_d        = 2'd2;
          end else begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
            rsp_tag_d    = head.tag;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if ((lag_q == 2'd0) && fpu_valid) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = fpu_result;
          rsp_err_d    = 1'b0;
          rsp_tag_d    = cur_tag_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT cycles spent in WAIT with no result
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_tag_d    = cur_tag_q;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    // ready is a register of next-cycle fullness, so a pop never frees a slot the same cycle
    cmd_ready_d = ((wr_ptr_d - rd_ptr_d) != PW'(DEPTH));
  end

  // State register
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lag_q        <= '0;
      timer_q      <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= '0;
      fpu_enable_q <= 1'b0;
      cur_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lag_q        <= lag_d;
      timer_q      <= timer_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      fpu_op_q     <= fpu_op_d;
      fpu_enable_q <= fpu_enable_d;
      cur_tag_q    <= cur_tag_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_enable = fpu_enable_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Testbench for fpu_dispatch: scoreboard of expected responses, a behavioural
// controller model with per-command latency, directed scenarios and random traffic.
module tb_fpu_dispatch;

  localparam int unsigned PL      = 64;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 63;
  localparam int          NEVER   = -1;

  logic           clk = 1'b0;
  logic           srstn = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = '0;
  logic [PL-1:0]  cmd_a = '0, cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [PL-1:0]  rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic           rsp_err;
  logic [PL-1:0]  fpu_a, fpu_b;
  logic [3:0]     fpu_op;
  logic           fpu_enable;
  logic           fpu_busy = 1'b0;
  logic           fpu_valid = 1'b0;
  logic [PL-1:0]  fpu_result = '0;

  int errors = 0;
  int checks = 0;
  bit rnd = 1'b0;

  logic [68:0] exp_q [$];   // {tag, err, result}
  int          lat_q [$];   // controller latency for each legal command, in order

  fpu_dispatch #(.PRECISION_LEN(PL), .DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .srstn(srstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_enable(fpu_enable),
    .fpu_busy(fpu_busy), .fpu_valid(fpu_valid), .fpu_result(fpu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // What the controller computes: true double multiply for MUL (3), a mixing function otherwise
  function automatic logic [PL-1:0] fmodel(input logic [3:0] op, input logic [PL-1:0] a,
                                           input logic [PL-1:0] b);
    if (op == 4'd3) return $realtobits($bitstoreal(a) * $bitstoreal(b));
    return (a ^ {b[31:0], b[63:32]}) + 64'(op);
  endfunction

  // Drive one command and record its expected response when accepted
  task automatic push(input logic [3:0] op, input logic [PL-1:0] a, input logic [PL-1:0] b,
                      input logic [TAG_W-1:0] tag, input int lat);
    int n = 0;
    bit legal;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    while (!cmd_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin
      chk("push_timeout", 1, 0);
    end else begin
      legal = (op >= 4'd1) && (op <= 4'd9);
      if (legal) begin
        lat_q.push_back(lat);
        if (lat == NEVER) exp_q.push_back({tag, 1'b1, 64'd0});
        else              exp_q.push_back({tag, 1'b0, fmodel(op, a, b)});
      end else begin
        exp_q.push_back({tag, 1'b1, 64'd0});
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_enable(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!fpu_enable && cyc < 300);
    if (!fpu_enable) chk("enable_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rsp_valid && cyc < 300);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  // Controller model: valid is stale garbage during the lag window, then the real result
  initial begin : ctrl_model
    int d;
    logic [PL-1:0] r;
    forever begin
      @(negedge clk);
      if (srstn && fpu_enable) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_enable: op %0h with no legal command outstanding", fpu_op);
        end else begin
          d = lat_q.pop_front();
          r = fmodel(fpu_op, fpu_a, fpu_b);
          @(posedge clk); #1;
          fpu_valid = 1'b1; fpu_result = ~r;
          @(posedge clk); #1;
          fpu_valid = 1'b0;
          if (d != NEVER) begin
            repeat (d) begin @(posedge clk); #1; end
            fpu_valid = 1'b1; fpu_result = r;
            @(posedge clk); #1;
          end
          fpu_valid = 1'b0; fpu_result = ~r;
        end
      end
    end
  end

  // Monitor: pops expectations on handshakes and checks stability while stalled
  initial begin : monitor
    logic [68:0] held, e;
    bit hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!srstn) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("rsp_stable", {rsp_valid, rsp_tag, rsp_err, rsp_result}, {1'b1, held});
          hold = 1'b0;
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {rsp_tag, rsp_err, rsp_result}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_fields", {rsp_tag, rsp_err, rsp_result}, e);
          end
        end else if (rsp_valid) begin
          hold = 1'b1;
          held = {rsp_tag, rsp_err, rsp_result};
        end
      end
    end
  end

  // Random back-pressure and busy while the random phase runs
  initial begin : rnd_drv
    forever begin
      @(posedge clk); #1;
      if (rnd) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        fpu_busy  = ($urandom_range(0, 5) == 0);
      end
    end
  end

  initial begin : stim
    int c, cnt;
    logic [3:0] op;
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_err, fpu_op, fpu_enable},
        {1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 4'd0, 1'b0});
    chk("reset_operands", {fpu_a, fpu_b}, 0);
    srstn = 1'b1;
    repeat (2) @(negedge clk);

    // MUL 2.0 * 3.0, zero-cycle controller, minimum latency
    push(4'd3, 64'h4000000000000000, 64'h4008000000000000, 4'd5, 0);
    wait_rsp(cnt);
    chk("min_latency", 128'(cnt), 5);
    chk("mul_result", {rsp_tag, rsp_err, rsp_result}, {4'd5, 1'b0, 64'h4018000000000000});
    chk("fpu_operands_held", {fpu_a, fpu_b}, {64'h4000000000000000, 64'h4008000000000000});
    drain();

    // illegal opcode: error response, no issue
    push(4'hF, 64'h1234, 64'h5678, 4'd3, 0);
    push(4'h0, 64'h1, 64'h2, 4'd4, 0);
    drain();

    // full FIFO with controller busy, then release
    fpu_busy = 1'b1;
    for (int i = 1; i <= 4; i++) push(4'd1, 64'(i * 3), 64'(i * 7), 4'(i), 1);
    chk("full_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 64'd99; cmd_b = 64'd11; cmd_tag = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("fifth_held", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    fpu_busy = 1'b0;
    push(4'd2, 64'd99, 64'd11, 4'd5, 2);
    drain();

    // timeout exactly TIMEOUT cycles after entering WAIT
    push(4'd4, 64'hABCD, 64'h1111, 4'd7, NEVER);
    wait_enable(c);
    wait_rsp(cnt);
    chk("timeout_cycles", 128'(cnt), TIMEOUT + 1);
    chk("timeout_rsp", {rsp_tag, rsp_err, rsp_result}, {4'd7, 1'b1, 64'd0});
    drain();

    // response stall with queued commands
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4'(i + 5), 64'(i + 100), 64'(i + 200), 4'(i + 8), 1);
    wait_rsp(cnt);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_no_enable", fpu_enable, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_enable(cnt);
    chk("issue_after_handshake", 128'(cnt), 3);
    drain();

    // reset in the middle of WAIT
    push(4'd6, 64'h77, 64'h88, 4'd9, NEVER);
    wait_enable(c);
    repeat (3) @(negedge clk);
    srstn = 1'b0;
    #1;
    chk("midop_reset_outputs",
        {cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_err, fpu_op, fpu_enable, fpu_a, fpu_b},
        {1'b1, 1'b0, 64'd0, 4'd0, 1'b0, 4'd0, 1'b0, 64'd0, 64'd0});
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    srstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid || fpu_enable) cnt++;
    end
    chk("no_stale_rsp", 128'(cnt), 0);

    // random traffic
    rnd = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 8) op = 4'($urandom_range(1, 9));
      else op = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(10, 15)) : 4'd0;
      push(op, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom),
           ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 6)));
    end
    rnd = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    fpu_busy  = 1'b0;
    drain();
    chk("queue_drained", 128'(exp_q.size() + lat_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
